// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sampler.
// Holds the receive state encoding, frame geometry and a parity helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_e;

    localparam int UART_MIN_DIV   = 4;
    localparam int UART_DATA_BITS = 8;

    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: head entry is always presented on pop_dat while not empty.
// Latency: a push is visible on the cycle after the write edge; a pop exposes the next entry one cycle later.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop synchronizer, mid-bit sampler, optional even parity, show-ahead output FIFO.
// Latency: byte visible on valid_o the cycle after the stop-bit sample edge; errors pulse on that same cycle.
// Backpressure: ready_i pops the FIFO; a completed byte arriving while the FIFO is full is dropped with overrun_o.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_WIDTH-1:0]        cfg_div_i,
    input  logic                        rx_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        frame_err_o,
    output logic                        parity_err_o,
    output logic                        overrun_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int BIT_IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV   = DIV_WIDTH'(UART_MIN_DIV);
    localparam logic [BIT_IDX_W-1:0] IDX_ONE   = BIT_IDX_W'(1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(UART_DATA_BITS - 1);

    logic                      sync1;
    logic                      rx_s;
    uart_rx_state_e            state;
    logic [DIV_WIDTH-1:0]      cnt;
    logic [DIV_WIDTH-1:0]      div_q;
    logic [DIV_WIDTH-1:0]      div_eff;
    logic [BIT_IDX_W-1:0]      bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      par_flag;
    logic                      frame_err_q;
    logic                      parity_err_q;
    logic                      overrun_q;
    logic                      sample_tick;
    logic                      push_vld;
    logic                      pop_fire;
    logic                      fifo_full;
    logic                      fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rx_s  <= sync1;
        end
    end

    assign div_eff     = (cfg_div_i < MIN_DIV) ? MIN_DIV : cfg_div_i;
    assign sample_tick = (cnt == '0);

    // The push is taken combinationally on the stop sample edge so the byte
    // lands in the FIFO on that edge and valid_o rises one cycle later.
    assign push_vld = (state == STOP) && sample_tick && rx_s && !par_flag;
    assign pop_fire = ready_i && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            div_q        <= MIN_DIV;
            bit_idx      <= '0;
            shift        <= '0;
            par_flag     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        div_q    <= div_eff;
                        cnt      <= (div_eff >> 1) - CNT_ONE;
                        par_flag <= 1'b0;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            cnt     <= div_q - CNT_ONE;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        cnt     <= div_q - CNT_ONE;
                        bit_idx <= bit_idx + IDX_ONE;
                        if (bit_idx == IDX_LAST) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PARITY: begin
                    if (sample_tick) begin
                        par_flag <= (rx_s != even_parity(shift));
                        cnt      <= div_q - CNT_ONE;
                        state    <= STOP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_IDLE;
                        end else begin
                            parity_err_q <= par_flag;
                            state        <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) reports once, then waits for idle.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_vld && fifo_full && !pop_fire;
        end
    end

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (shift),
        .pop_rdy  (ready_i),
        .pop_dat  (data_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

    assign valid_o      = !fifo_empty;
    assign busy_o       = (state != IDLE);
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: one instance without parity, one with even parity.
// Expected bytes are queued as frames are driven and checked at each output handshake.
module tb_uart_rx_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        rx0, rx1, ready0, ready1;
    logic [7:0]  data0, data1;
    logic        valid0, valid1, ferr0, ferr1, perr0, perr1, ovr0, ovr1, busy0, busy1;
    logic [3:0]  level0, level1;

    int total = 0;
    int bad   = 0;
    int ferr_cnt0 = 0, perr_cnt0 = 0, ovr_cnt0 = 0;
    int ferr_cnt1 = 0, perr_cnt1 = 0, ovr_cnt1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    uart_rx_sampler #(.DIV_WIDTH(16), .FIFO_DEPTH(8), .PARITY_EN(0)) u0 (
        .clk(clk), .rst(rst), .cfg_div_i(cfg_div), .rx_i(rx0),
        .data_o(data0), .valid_o(valid0), .ready_i(ready0),
        .frame_err_o(ferr0), .parity_err_o(perr0), .overrun_o(ovr0),
        .busy_o(busy0), .level_o(level0)
    );

    uart_rx_sampler #(.DIV_WIDTH(16), .FIFO_DEPTH(8), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .cfg_div_i(cfg_div), .rx_i(rx1),
        .data_o(data1), .valid_o(valid1), .ready_i(ready1),
        .frame_err_o(ferr1), .parity_err_o(perr1), .overrun_o(ovr1),
        .busy_o(busy1), .level_o(level1)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every handshake against the queued expectation.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        #1;
        if (valid0 && ready0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL pop0_unexpected: got 0x%02h, expected no byte", data0);
            end else begin
                e = q0.pop_front();
                if (data0 !== e) begin
                    bad++;
                    $display("FAIL pop0_data: got 0x%02h, expected 0x%02h", data0, e);
                end
            end
        end
        if (valid1 && ready1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL pop1_unexpected: got 0x%02h, expected no byte", data1);
            end else begin
                e = q1.pop_front();
                if (data1 !== e) begin
                    bad++;
                    $display("FAIL pop1_data: got 0x%02h, expected 0x%02h", data1, e);
                end
            end
        end
        if (ferr0) ferr_cnt0++;
        if (perr0) perr_cnt0++;
        if (ovr0)  ovr_cnt0++;
        if (ferr1) ferr_cnt1++;
        if (perr1) perr_cnt1++;
        if (ovr1)  ovr_cnt1++;
    end

    task automatic drive(input int dut, input logic v);
        if (dut == 0) rx0 = v;
        else          rx1 = v;
    endtask

    // Frame starts on the next falling clock edge; every bit lasts max(cfg,4) cycles.
    task automatic send_frame(input int dut, input int cfg, input logic [7:0] b,
                              input bit has_par, input logic par,
                              input int stop_low, input int cfg_mid);
        int bl;
        bl = (cfg < 4) ? 4 : cfg;
        @(negedge clk);
        cfg_div = 16'(cfg);
        drive(dut, 1'b0);
        repeat (bl) @(negedge clk);
        if (cfg_mid != 0) cfg_div = 16'(cfg_mid);
        for (int i = 0; i < 8; i++) begin
            drive(dut, b[i]);
            repeat (bl) @(negedge clk);
        end
        if (has_par) begin
            drive(dut, par);
            repeat (bl) @(negedge clk);
        end
        if (stop_low > 0) begin
            drive(dut, 1'b0);
            repeat (stop_low * bl) @(negedge clk);
        end
        drive(dut, 1'b1);
        repeat (bl) @(negedge clk);
        cfg_div = 16'(cfg);
    endtask

    typedef struct {
        int         cfg;
        logic [7:0] b;
        int         stop_low;
        int         cfg_mid;
        bit         exp_push;
        int         exp_ferr;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[9];
        int   n, f0, p0, o0, f1, p1, o1;

        vecs[0] = '{16, 8'h55, 0, 0,  1'b1, 0};
        vecs[1] = '{16, 8'hA3, 0, 0,  1'b1, 0};
        vecs[2] = '{2,  8'h3C, 0, 0,  1'b1, 0};
        vecs[3] = '{5,  8'h81, 0, 0,  1'b1, 0};
        vecs[4] = '{16, 8'h0F, 3, 0,  1'b0, 1};
        vecs[5] = '{16, 8'h42, 0, 0,  1'b1, 0};
        vecs[6] = '{16, 8'hC6, 0, 40, 1'b1, 0};
        vecs[7] = '{4,  8'h00, 0, 0,  1'b1, 0};
        vecs[8] = '{16, 8'hFF, 0, 0,  1'b1, 0};

        rst = 1'b1; cfg_div = 16'd16; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid0", int'(valid0), 0);
        check("rst_data0",  int'(data0), 0);
        check("rst_level0", int'(level0), 0);
        check("rst_busy0",  int'(busy0), 0);
        check("rst_errs0",  int'({ferr0, perr0, ovr0}), 0);
        check("rst_valid1", int'(valid1), 0);
        check("rst_level1", int'(level1), 0);
        check("rst_errs1",  int'({ferr1, perr1, ovr1, busy1}), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 3-cycle low glitch: start seen 3 edges after the fall, rejected at the start sample.
        rx0 = 1'b0;
        @(negedge clk); @(negedge clk);
        check("start_latency_pre", int'(busy0), 0);
        @(negedge clk);
        check("start_latency_busy", int'(busy0), 1);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", int'(busy0), 0);
        check("glitch_level", int'(level0), 0);
        check("glitch_errs", ferr_cnt0 + perr_cnt0 + ovr_cnt0, 0);

        // Stop sample is 3 + 8 + 9*16 = 155 edges after the falling edge.
        ready0 = 1'b0;
        q0.push_back(8'h5A);
        fork
            send_frame(0, 16, 8'h5A, 1'b0, 1'b0, 0, 0);
            begin
                @(negedge clk);
                n = 0;
                while (!valid0 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("valid_rise_cycle", n, 155);
                check("showahead_data", int'(data0), 8'h5A);
            end
        join
        ready0 = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back frames.
        q0.push_back(8'h55); send_frame(0, 16, 8'h55, 1'b0, 1'b0, 0, 0);
        q0.push_back(8'hA3); send_frame(0, 16, 8'hA3, 1'b0, 1'b0, 0, 0);
        repeat (40) @(negedge clk);
        check("b2b_delivered", q0.size(), 0);

        for (int i = 0; i < 9; i++) begin
            f0 = ferr_cnt0; p0 = perr_cnt0; o0 = ovr_cnt0;
            if (vecs[i].exp_push) q0.push_back(vecs[i].b);
            send_frame(0, vecs[i].cfg, vecs[i].b, 1'b0, 1'b0, vecs[i].stop_low, vecs[i].cfg_mid);
            repeat (40) @(negedge clk);
            check($sformatf("vec%0d_busy", i), int'(busy0), 0);
            check($sformatf("vec%0d_ferr", i), ferr_cnt0 - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr_ovr", i), (perr_cnt0 - p0) + (ovr_cnt0 - o0), 0);
            check($sformatf("vec%0d_drained", i), q0.size(), 0);
        end

        // Parity instance: bad parity, good parity, and frame error taking precedence.
        f1 = ferr_cnt1; p1 = perr_cnt1;
        send_frame(1, 16, 8'h07, 1'b1, 1'b0, 0, 0);
        repeat (20) @(negedge clk);
        check("par_bad_perr", perr_cnt1 - p1, 1);
        check("par_bad_level", int'(level1), 0);
        q1.push_back(8'h07);
        send_frame(1, 16, 8'h07, 1'b1, 1'b1, 0, 0);
        q1.push_back(8'hA5);
        send_frame(1, 16, 8'hA5, 1'b1, 1'b0, 0, 0);
        repeat (20) @(negedge clk);
        check("par_good_delivered", q1.size(), 0);
        send_frame(1, 16, 8'h07, 1'b1, 1'b0, 1, 0);
        repeat (20) @(negedge clk);
        check("par_frame_ferr", ferr_cnt1 - f1, 1);
        check("par_frame_perr", perr_cnt1 - p1, 1);
        check("par_busy", int'(busy1), 0);

        // Overrun: fill the FIFO, drop the 9th byte, then push+pop while full.
        ready0 = 1'b0;
        o0 = ovr_cnt0;
        for (int i = 1; i <= 8; i++) begin
            q0.push_back(8'(i));
            send_frame(0, 16, 8'(i), 1'b0, 1'b0, 0, 0);
        end
        check("ovr_none_yet", ovr_cnt0 - o0, 0);
        send_frame(0, 16, 8'h09, 1'b0, 1'b0, 0, 0);
        check("ovr_level_full", int'(level0), 8);
        check("ovr_pulse", ovr_cnt0 - o0, 1);
        check("ovr_head", int'(data0), 8'h01);
        q0.push_back(8'h0A);
        fork
            send_frame(0, 16, 8'h0A, 1'b0, 1'b0, 0, 0);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                ready0 = 1'b1;
                @(negedge clk);
                ready0 = 1'b0;
            end
        join
        check("full_pushpop_ovr", ovr_cnt0 - o0, 1);
        check("full_pushpop_level", int'(level0), 8);
        check("full_pushpop_head", int'(data0), 8'h02);
        ready0 = 1'b1;
        n = 0;
        while ((level0 != 0 || q0.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_level", int'(level0), 0);
        check("drain_queue", q0.size(), 0);

        // Reset in the middle of a frame: partial byte lost, no error pulses.
        f0 = ferr_cnt0; p0 = perr_cnt0; o0 = ovr_cnt0;
        fork
            send_frame(0, 16, 8'hFF, 1'b0, 1'b0, 0, 0);
            begin
                @(negedge clk);
                repeat (60) @(negedge clk);
                check("midrst_busy_before", int'(busy0), 1);
                rst = 1'b1;
                @(negedge clk); @(negedge clk);
                rst = 1'b0;
                check("midrst_busy_after", int'(busy0), 0);
                check("midrst_level", int'(level0), 0);
            end
        join
        q0.push_back(8'h3C);
        send_frame(0, 16, 8'h3C, 1'b0, 1'b0, 0, 0);
        repeat (20) @(negedge clk);
        check("midrst_delivered", q0.size(), 0);
        check("midrst_errs", (ferr_cnt0 - f0) + (perr_cnt0 - p0) + (ovr_cnt0 - o0), 0);
        check("final_q1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Synthesizable UART receiver that consumes the serial `uart_tx` line driven by `pulpino_top` and turns it into a byte stream for on-chip checkers and the FPGA console bridge. It replaces the behavioural bench receiver with a cycle-exact block:
- 2-flop input synchronizer
- mid-bit sampling via a programmable divider
- optional even-parity check
- small show-ahead FIFO with valid/ready output

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the clocks-per-bit divisor
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥2
- `PARITY_EN`, 0, 1 = one even-parity bit between data and stop

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `cfg_div_i` in DIV_WIDTH: clocks per bit (50 MHz / 3125000 baud = 16); values <4 are treated as 4
- `rx_i` in 1: asynchronous serial input, idle high
- `data_o` out 8: head-of-FIFO byte
- `valid_o` out 1: FIFO not empty
- `ready_i` in 1: consumer accepts `data_o` when `valid_o & ready_i`
- `frame_err_o` out 1: one-cycle pulse, stop bit sampled low
- `parity_err_o` out 1: one-cycle pulse, parity mismatch (PARITY_EN=1 only)
- `overrun_o` out 1: one-cycle pulse, byte dropped because FIFO full
- `busy_o` out 1: FSM not in IDLE
- `level_o` out $clog2(FIFO_DEPTH)+1: FIFO occupancy

## Operation
- **Synchronizer:** two flops, both reset to 1; the FSM sees only `rx_s`.
- **Divisor latch:** at start detection, `div_q = max(cfg_div_i, 4)`. `cfg_div_i` changes mid-frame have no effect.
- **FSM states** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE:
  - IDLE: `rx_s == 0` → START; counter loaded with `(div_q>>1)-1`.
  - START: at counter 0, sample `rx_s`. If 1 → IDLE (glitch, no error). If 0 → DATA, counter `div_q-1`, bit index 0.
  - DATA: at counter 0, shift `rx_s` in LSB first; after bit 7 → PARITY if PARITY_EN, else STOP. Counter reloads `div_q-1` at every sample.
  - PARITY: at counter 0, compare `rx_s` with XOR of the data bits (even parity); mismatch sets a flag. → STOP.
  - STOP, at counter 0:
    - `rx_s == 1` and no parity flag → push byte; → IDLE.
    - `rx_s == 1` with parity flag → `parity_err_o` pulse, byte discarded; → IDLE.
    - `rx_s == 0` → `frame_err_o` pulse, byte discarded; → WAIT_IDLE (this takes precedence over a parity error).
  - WAIT_IDLE: stay until `rx_s == 1`, then → IDLE. A break condition produces exactly one `frame_err_o`.
- **FIFO:** show-ahead.
  - Push while full with no simultaneous pop: byte dropped, `overrun_o` pulse, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; `level_o` is exact (0..FIFO_DEPTH).
- **Reset mid-frame:** the FSM returns to IDLE and the FIFO empties. The partial byte is lost and no error pulses are generated.

## Timing
- Reset values:
  - `valid_o`=0, `data_o`=0, `level_o`=0
  - all error pulses 0, `busy_o`=0
  - synchronizer flops 1, FSM IDLE
- Start-edge latency: `rx_i` falling edge → START after 2 synchronizer cycles + 1 FSM cycle.
- Sample points at offsets `div_q/2`, `div_q/2 + k*div_q` (k=1..9 or 10) from start detection.
- Byte visible: `valid_o` rises the cycle after the STOP sample edge. Error pulses are asserted on that same cycle.
- Pop latency: the next entry appears on `data_o` in the cycle after the handshake.
- Back-to-back frames: a start bit immediately following the stop sample is detected with no lost cycles; worst case start-after-stop gap is 0 bit times.

## Structure
- **Package `uart_rx_pkg`:**
  - `uart_rx_state_e` enum
  - `UART_MIN_DIV = 4`
  - `UART_DATA_BITS = 8`
- **Sub-module `uart_rx_fifo`:** parameterized width/depth, show-ahead, with push/pop/full/empty/level. The top holds the synchronizer, FSM, counters, shift register and parity.

## Test plan
- Div=16, send 0x55 then 0xA3, `ready_i`=1 → two handshakes with `data_o` 0x55, 0xA3; no error pulses; `busy_o` low between frames.
- 3-cycle low glitch on idle `rx_i` (div=16) → FSM returns to IDLE, no push, no errors.
- Frame 0x0F with stop bit held low for 3 bit times, then a valid 0x42 → one `frame_err_o` pulse, then 0x42 delivered.
- PARITY_EN=1, send 0x07 with parity bit 0 → `parity_err_o` pulse, nothing pushed; same byte with parity 1 → 0x07 delivered.
- `ready_i`=0, send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 → `level_o`=8, `overrun_o` pulses on byte 9. Raising `ready_i` yields 0x01..0x08.
- Assert `rst` during DATA of byte 0xFF, release, send 0x3C → only 0x3C delivered, no error pulses.
